// File: rtl/sync_updown_counter_if.sv
// Control and status bundle for sync_updown_counter.
// The master drives the count controls; the slave returns the count and its flags.
interface sync_updown_counter_if #(
  parameter int unsigned WIDTH = 4
);
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             en;
  logic             up;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             wrap;
  logic             ovf;

  modport master (
    output clr, load, load_val, en, up,
    input  q, tc, wrap, ovf
  );

  modport slave (
    input  clr, load, load_val, en, up,
    output q, tc, wrap, ovf
  );
endinterface

// File: rtl/sync_updown_counter.sv
// Parametrised up/down counter with load, clear, wrap/saturate and flag outputs.
// All state changes on the falling edge of clk; reset is synchronous, active high.
module sync_updown_counter #(
  parameter int unsigned      WIDTH     = 4,
  parameter logic [WIDTH-1:0] MAX_VAL   = {WIDTH{1'b1}},
  parameter bit               SATURATE  = 1'b0,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic                  clk,
  input logic                  reset,
  sync_updown_counter_if.slave bus
);

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  logic             ovf_q, ovf_d;
  logic             at_max;
  logic             at_min;

  assign at_max = (q_q == MAX_VAL);
  assign at_min = (q_q == '0);

  // Priority clr > load > en; reset is handled in the flop block.
  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    ovf_d  = ovf_q;
    if (bus.clr) begin
      q_d   = RESET_VAL;
      ovf_d = 1'b0;
    end else if (bus.load) begin
      q_d = (bus.load_val > MAX_VAL) ? MAX_VAL : bus.load_val;
    end else if (bus.en) begin
      if (bus.up) begin
        if (!at_max) begin
          q_d = q_q + WIDTH'(1);
        end else begin
          ovf_d = 1'b1;
          if (!SATURATE) begin
            q_d    = '0;
            wrap_d = 1'b1;
          end
        end
      end else begin
        if (!at_min) begin
          q_d = q_q - WIDTH'(1);
        end else begin
          ovf_d = 1'b1;
          if (!SATURATE) begin
            q_d    = MAX_VAL;
            wrap_d = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(negedge clk) begin
    if (reset) begin
      q_q    <= RESET_VAL;
      wrap_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
      ovf_q  <= ovf_d;
    end
  end

  assign bus.q    = q_q;
  assign bus.wrap = wrap_q;
  assign bus.ovf  = ovf_q;
  assign bus.tc   = bus.en & ((bus.up & at_max) | (~bus.up & at_min));

endmodule
